// File: rtl/jtag_dr_pkg.sv
// Shared definitions for the JTAG DR-scan core: FSM state encoding and default field widths.
// Optional length check is enabled with JTAG_DR_LEN_CHECK_EN (see jtag_dr_core).
package jtag_dr_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_EXIT   = 2'd2,
        ST_COMMIT = 2'd3
    } dr_state_e;

endpackage

// File: rtl/jtag_dr_core_if.sv
// TAP-strobe / register bus between the TAP controller side and the DR core.
// err_o exists only when JTAG_DR_LEN_CHECK_EN is defined.
interface jtag_dr_core_if import jtag_dr_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              tdi_i;
    logic              tdo_o;
    logic              capture_i;
    logic              shift_i;
    logic              e1dr_i;
    logic              update_i;
    logic [DATA_W-1:0] reg_q_i;
    logic [ADDR_W-1:0] reg_addr_q_i;
    logic [DATA_W-1:0] reg_d_o;
    logic [ADDR_W-1:0] reg_addr_d_o;
    logic              reg_update_o;
    logic              busy_o;
`ifdef JTAG_DR_LEN_CHECK_EN
    logic              err_o;
`endif

    modport slave (
        input  tdi_i, capture_i, shift_i, e1dr_i, update_i, reg_q_i, reg_addr_q_i,
        output tdo_o, reg_d_o, reg_addr_d_o, reg_update_o, busy_o
`ifdef JTAG_DR_LEN_CHECK_EN
        , output err_o
`endif
    );

    modport master (
        output tdi_i, capture_i, shift_i, e1dr_i, update_i, reg_q_i, reg_addr_q_i,
        input  tdo_o, reg_d_o, reg_addr_d_o, reg_update_o, busy_o
`ifdef JTAG_DR_LEN_CHECK_EN
        , input err_o
`endif
    );

endinterface

// File: rtl/jtag_shift_reg.sv
// Parallel-load, LSB-first shift register with serial out at bit 0; load wins over shift.
// One-cycle update, no backpressure.
module jtag_shift_reg #(
    parameter int WIDTH = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_dat_i,
    input  logic             shift_i,
    input  logic             sdi_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sdo_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_dat_i;
        end else if (shift_i) begin
            sr_d = {sdi_i, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o   = sr_q;
    assign sdo_o = sr_q[0];

endmodule

// File: rtl/jtag_dr_core.sv
// DR-scan consumer: capture/shift/update of a {data, addr} register with a one-cycle commit pulse.
// Commit visible the cycle after update_i; define JTAG_DR_LEN_CHECK_EN to reject short/long scans via err_o.
module jtag_dr_core import jtag_dr_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           tap_reset_i,
    jtag_dr_core_if.slave  bus
);

    localparam int DR_LEN = DATA_W + ADDR_W;
    localparam int CNT_W  = $clog2(DR_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DR_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_LEN);

    logic              rst;
    dr_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] reg_d_q, reg_d_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic              sr_load, sr_shift, commit;
    logic [DR_LEN-1:0] sr;
`ifdef JTAG_DR_LEN_CHECK_EN
    logic              err_q, err_d;
`endif

    assign rst = rst_i | tap_reset_i;

    jtag_shift_reg #(.WIDTH(DR_LEN)) u_sr (
        .clk_i      (clk_i),
        .rst_i      (rst),
        .load_i     (sr_load),
        .load_dat_i ({bus.reg_q_i, bus.reg_addr_q_i}),
        .shift_i    (sr_shift),
        .sdi_i      (bus.tdi_i),
        .q_o        (sr),
        .sdo_o      (bus.tdo_o)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        commit     = 1'b0;
`ifdef JTAG_DR_LEN_CHECK_EN
        err_d      = err_q;
`endif
        if (bus.capture_i) begin
            sr_load = 1'b1;
            cnt_d   = '0;
            state_d = ST_SHIFT;
`ifdef JTAG_DR_LEN_CHECK_EN
            err_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_SHIFT: begin
                    if (bus.shift_i) begin
                        sr_shift = 1'b1;
                        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    end else if (bus.e1dr_i) begin
                        state_d = ST_EXIT;
                    end
                end
                ST_EXIT: begin
                    // Pause/exit2 re-entry shifts in the same cycle it returns to SHIFT.
                    if (bus.shift_i) begin
                        sr_shift = 1'b1;
                        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                        state_d  = ST_SHIFT;
                    end else if (bus.update_i) begin
`ifdef JTAG_DR_LEN_CHECK_EN
                        if (cnt_q == CNT_FULL) begin
                            commit = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
`else
                        commit = 1'b1;
`endif
                    end
                end
                ST_COMMIT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
        if (commit) begin
            state_d = ST_COMMIT;
        end
    end

    assign reg_d_d    = commit ? sr[DR_LEN-1:ADDR_W] : reg_d_q;
    assign reg_addr_d = commit ? sr[ADDR_W-1:0]      : reg_addr_q;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            reg_d_q    <= '0;
            reg_addr_q <= '0;
`ifdef JTAG_DR_LEN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reg_d_q    <= reg_d_d;
            reg_addr_q <= reg_addr_d;
`ifdef JTAG_DR_LEN_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign bus.reg_d_o      = reg_d_q;
    assign bus.reg_addr_d_o = reg_addr_q;
    assign bus.reg_update_o = (state_q == ST_COMMIT);
    assign bus.busy_o       = (state_q != ST_IDLE);
`ifdef JTAG_DR_LEN_CHECK_EN
    assign bus.err_o        = err_q;
`endif

endmodule

// File: tb/tb_jtag_dr_core.sv
// Self-checking bench for jtag_dr_core: directed scans plus randomized scans against a bit-level model.
// Build with JTAG_DR_LEN_CHECK_EN defined to also exercise err_o.
module tb_jtag_dr_core;

`ifdef JTAG_DR_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic tap_reset_i = 1'b0;

    jtag_dr_core_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    jtag_dr_core #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .tap_reset_i (tap_reset_i),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int dut_pulses = 0;

    // Reference model: the DR as a plain 11-bit number plus scan bookkeeping.
    logic [10:0] m_sr;
    int          m_n;
    bit          m_scan, m_exit, m_pulse, m_err;
    logic [7:0]  m_d;
    logic [2:0]  m_a;

    logic        last_tdo;
    logic        tdo_seen [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst_i || tap_reset_i) begin
            m_sr = '0; m_n = 0; m_scan = 0; m_exit = 0; m_pulse = 0;
            m_d = '0; m_a = '0; m_err = 0;
        end else if (bus.capture_i) begin
            m_sr = {bus.reg_q_i, bus.reg_addr_q_i};
            m_n = 0; m_scan = 1; m_exit = 0; m_pulse = 0; m_err = 0;
        end else begin
            m_pulse = 0;
            if (m_scan && bus.shift_i) begin
                m_sr = (m_sr >> 1) | (11'(bus.tdi_i) << 10);
                if (m_n < 12) m_n++;
                m_exit = 0;
            end else if (m_scan && !m_exit && bus.e1dr_i) begin
                m_exit = 1;
            end else if (m_scan && m_exit && bus.update_i) begin
                if (!CHK || m_n == 11) begin
                    m_d = m_sr[10:3];
                    m_a = m_sr[2:0];
                    m_pulse = 1;
                end else begin
                    m_err = 1;
                end
                m_scan = 0;
                m_exit = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (bus.reg_update_o === 1'b1) dut_pulses++;
            check("tdo",        bus.tdo_o,        m_sr[0]);
            check("reg_d",      bus.reg_d_o,      m_d);
            check("reg_addr_d", bus.reg_addr_d_o, m_a);
            check("reg_update", bus.reg_update_o, m_pulse);
            check("busy",       bus.busy_o,       m_scan || m_pulse);
`ifdef JTAG_DR_LEN_CHECK_EN
            check("err",        bus.err_o,        m_err);
`endif
        end
    end

    task automatic drv(input bit cap, input bit sh, input bit e1, input bit up, input bit td);
        @(negedge clk);
        last_tdo          = bus.tdo_o;
        bus.capture_i     = cap;
        bus.shift_i       = sh;
        bus.e1dr_i        = e1;
        bus.update_i      = up;
        bus.tdi_i         = td;
        bus.reg_q_i       = 8'($urandom);
        bus.reg_addr_q_i  = 3'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) drv(0, 0, 0, 0, 0);
    endtask

    task automatic capture(input logic [7:0] q, input logic [2:0] a, input bit sh, input bit td);
        drv(1, sh, 0, 0, td);
        bus.reg_q_i      = q;
        bus.reg_addr_q_i = a;
    endtask

    task automatic scan(input logic [7:0] q, input logic [2:0] a, input logic [15:0] din,
                        input int nb, input int pause_at, input int pause_len,
                        input int upd_hold, input bit cap_sh);
        capture(q, a, cap_sh, cap_sh);
        for (int i = 0; i < nb; i++) begin
            if (i == pause_at) begin
                drv(0, 0, 1, 0, 0);
                idle(pause_len);
            end
            drv(0, 1, 0, 0, din[i]);
            tdo_seen[i] = last_tdo;
        end
        drv(0, 0, 1, 0, 0);
        repeat (upd_hold) drv(0, 0, 0, 1, 0);
        idle(2);
    endtask

    task automatic do_reset(input bit tap, input int n);
        drv(0, 0, 0, 0, 0);
        if (tap) tap_reset_i = 1'b1; else rst_i = 1'b1;
        repeat (n) @(negedge clk);
        rst_i = 1'b0;
        tap_reset_i = 1'b0;
    endtask

    int          base, op, nb, pa;
    logic [10:0] exp_tdo;
    logic [15:0] din;

    initial begin
        bus.capture_i = 0; bus.shift_i = 0; bus.e1dr_i = 0; bus.update_i = 0;
        bus.tdi_i = 0; bus.reg_q_i = '0; bus.reg_addr_q_i = '0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        idle(2);

        // Nominal write with captured read-back.
        base = dut_pulses;
        scan(8'hA5, 3'h2, 16'h05E3, 11, -1, 0, 1, 1'b0);
        exp_tdo = 11'h52A;
        for (int i = 0; i < 11; i++) check("nominal_tdo_seq", tdo_seen[i], exp_tdo[i]);
        check("nominal_data",   bus.reg_d_o,      8'hBC);
        check("nominal_addr",   bus.reg_addr_d_o, 3'h3);
        check("nominal_pulses", dut_pulses - base, 1);

        // Pause path lands on the same word as a continuous shift.
        scan(8'h00, 3'h0, 16'h0000, 11, -1, 0, 1, 1'b0);
        base = dut_pulses;
        scan(8'h11, 3'h5, 16'h05E3, 11, 6, 3, 1, 1'b0);
        check("pause_data",   bus.reg_d_o,      8'hBC);
        check("pause_addr",   bus.reg_addr_d_o, 3'h3);
        check("pause_pulses", dut_pulses - base, 1);

        // Reset mid-shift aborts the scan.
        capture(8'hFF, 3'h7, 0, 0);
        repeat (4) drv(0, 1, 0, 0, 1);
        do_reset(0, 2);
        check("rst_data", bus.reg_d_o,      8'h00);
        check("rst_addr", bus.reg_addr_d_o, 3'h0);
        check("rst_tdo",  bus.tdo_o,        1'b0);
        check("rst_busy", bus.busy_o,       1'b0);
        base = dut_pulses;
        drv(0, 0, 1, 0, 0);
        drv(0, 0, 0, 1, 0);
        idle(2);
        check("rst_no_pulse", dut_pulses - base, 0);

        // Stray update in IDLE, then update held for three cycles.
        base = dut_pulses;
        drv(0, 0, 0, 1, 0);
        idle(2);
        check("stray_idle_pulses", dut_pulses - base, 0);
        scan(8'h00, 3'h0, 16'h02A5, 11, -1, 0, 3, 1'b0);
        check("held_upd_pulses", dut_pulses - base, 1);
        check("held_upd_data",   bus.reg_d_o,      8'h54);
        check("held_upd_addr",   bus.reg_addr_d_o, 3'h5);

        // Capture wins over a simultaneous shift.
        scan(8'h3C, 3'h6, 16'h00F1, 11, -1, 0, 1, 1'b1);
        check("prio_tdo_after_capture", tdo_seen[0], 1'b0);
        check("prio_data", bus.reg_d_o,      8'h1E);
        check("prio_addr", bus.reg_addr_d_o, 3'h1);

`ifdef JTAG_DR_LEN_CHECK_EN
        base = dut_pulses;
        scan(8'h00, 3'h0, 16'h03FF, 10, -1, 0, 1, 1'b0);
        check("short_no_pulse", dut_pulses - base, 0);
        check("short_err",      bus.err_o,   1'b1);
        check("short_data",     bus.reg_d_o, 8'h1E);
        capture(8'h00, 3'h0, 0, 0);
        idle(1);
        check("err_cleared", bus.err_o, 1'b0);
        idle(2);
`endif

        // Randomized scans, stray strobes and resets; the model checks every cycle.
        for (int it = 0; it < 120; it++) begin
            op  = $urandom_range(0, 9);
            din = 16'($urandom);
            if (op <= 5) begin
                nb = (op <= 3) ? 11 : $urandom_range(9, 13);
                pa = $urandom_range(0, 1) ? $urandom_range(1, nb - 1) : -1;
                scan(8'($urandom), 3'($urandom), din, nb, pa, $urandom_range(0, 3),
                     $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            end else if (op == 6) begin
                drv(0, 0, 1'($urandom_range(0, 1)), 1, 1'($urandom));
                idle(1);
            end else if (op == 7) begin
                capture(8'($urandom), 3'($urandom), 0, 0);
                repeat ($urandom_range(0, 8)) drv(0, 1, 0, 0, 1'($urandom));
                do_reset(1'($urandom_range(0, 1)), $urandom_range(1, 2));
            end else begin
                repeat ($urandom_range(1, 4)) drv(0, 0, 0, 0, 1'($urandom));
            end
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
